l2_req_block_nch: RTL and testbench

Parametrised N-channel L2 request block, the next generation of the fixed two-channel L2 request merger. It groups masters into N_CH channels and runs round-robin arbitration inside each channel. Channels are then arbitrated by a runtime-weighted round-robin, and the winner is decoupled from the L2 slave through a small elastic output FIFO. Responses are routed back to masters by a one-hot ID that the block generates internally. It sits between the master-side crossbar ports and a single L2 bank/slave port.

---
 rtl/l2_xbar_pkg.sv | 40 ++++
 rtl/l2_req_block_nch_if.sv | 56 +++++
 rtl/l2_req_fifo.sv | 71 +++++++
 rtl/l2_req_block_nch.sv | 148 ++++++++++++++
 tb/tb_l2_req_block_nch.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/l2_xbar_pkg.sv
// Shared types and helpers for the L2 request path: the queued request entry,
// the circular first-set-bit search used by both arbitration levels, and the
// rule that turns a zero channel weight into a usable one.
package l2_xbar_pkg;

  localparam int L2_ADDR_W = 32;
  localparam int L2_DATA_W = 64;
  localparam int L2_BE_W   = L2_DATA_W / 8;
  localparam int L2_ID_W   = 8;

  // Widest request vector the circular search accepts (masters per channel or channels).
  localparam int L2_SRCH_W = 32;

  // A weight of zero would starve a channel forever; it is treated as this value instead.
  localparam int L2_W_ZERO_AS = 1;

  typedef struct packed {
    logic [L2_ADDR_W-1:0] add;
    logic                 wen;
    logic [L2_DATA_W-1:0] wdata;
    logic [L2_BE_W-1:0]   be;
    logic [L2_ID_W-1:0]   id;
  } l2_entry_t;

  // Index of the first set bit of req[n-1:0], searching upward from ptr and
  // wrapping. The bound is constant so the loop unrolls into a priority chain;
  // iterating from the far end lets the nearest hit overwrite the others.
  // Returns ptr when nothing is set (callers qualify with their own OR-reduce).
  function automatic int rr_search(input logic [L2_SRCH_W-1:0] req, input int ptr, input int n);
    int res;
    int idx;
    res = ptr;
    for (int k = L2_SRCH_W - 1; k >= 0; k--) begin
      idx = (ptr + k) % n;
      res = ((k < n) && req[idx]) ? idx : res;
    end
    return res;
  endfunction

endpackage

// File: rtl/l2_req_block_nch_if.sv
// Bus bundle between the master-side crossbar ports, the request block and
// the L2 slave. Signal suffixes are from the request block's point of view.
interface l2_req_block_nch_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int BE_WIDTH     = DATA_WIDTH / 8,
  parameter int N_CH         = 2,
  parameter int MPC          = 4,
  parameter int ID_WIDTH     = N_CH * MPC,
  parameter int WEIGHT_WIDTH = 4,
  parameter int OUT_DEPTH    = 2
);

  localparam int N_M   = N_CH * MPC;
  localparam int LVL_W = $clog2(OUT_DEPTH) + 1;

  // Master side
  logic [N_M-1:0]              data_req_i;
  logic [N_M*ADDR_WIDTH-1:0]   data_add_i;
  logic [N_M-1:0]              data_wen_i;
  logic [N_M*DATA_WIDTH-1:0]   data_wdata_i;
  logic [N_M*BE_WIDTH-1:0]     data_be_i;
  logic [N_M-1:0]              data_gnt_o;
  logic [N_M-1:0]              data_r_valid_o;
  logic [N_CH*WEIGHT_WIDTH-1:0] ch_weight_i;

  // Slave side
  logic                        data_req_o;
  logic [ADDR_WIDTH-1:0]       data_add_o;
  logic                        data_wen_o;
  logic [DATA_WIDTH-1:0]       data_wdata_o;
  logic [BE_WIDTH-1:0]         data_be_o;
  logic [ID_WIDTH-1:0]         data_ID_o;
  logic                        data_gnt_i;
  logic                        data_r_valid_i;
  logic [ID_WIDTH-1:0]         data_r_ID_i;

  logic [LVL_W-1:0]            fifo_level_o;

  // The request block itself
  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, ch_weight_i,
           data_gnt_i, data_r_valid_i, data_r_ID_i,
    output data_gnt_o, data_r_valid_o, data_req_o, data_add_o, data_wen_o,
           data_wdata_o, data_be_o, data_ID_o, fifo_level_o
  );

  // Environment driving the block (masters plus L2 bank)
  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, ch_weight_i,
           data_gnt_i, data_r_valid_i, data_r_ID_i,
    input  data_gnt_o, data_r_valid_o, data_req_o, data_add_o, data_wen_o,
           data_wdata_o, data_be_o, data_ID_o, fifo_level_o
  );

endinterface

// File: rtl/l2_req_fifo.sv
// Elastic output FIFO decoupling the arbiter from the L2 slave. A push while
// full is dropped even if a pop happens in the same cycle, so the upstream
// grant (which already looks at full) never has to see the pop.
module l2_req_fifo
  import l2_xbar_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  l2_entry_t        i_entry,
  input  logic             i_pop,
  output l2_entry_t        o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  l2_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;

  logic w_push_en;
  logic w_pop_en;

  // Qualify push/pop with the current occupancy.
  always_comb begin
    o_full    = (r_level == LVL_W'(DEPTH));
    o_empty   = (r_level == LVL_W'(0));
    w_push_en = i_push & ~o_full;
    w_pop_en  = i_pop & ~o_empty;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_level = r_level;

  // Storage, pointers and level; reset clears storage so the outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_en) begin
        r_mem[r_wptr] <= i_entry;
        r_wptr        <= r_wptr + PTR_W'(1);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_pop_en) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end else begin
        r_rptr <= r_rptr;
      end
      case ({w_push_en, w_pop_en})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/l2_req_block_nch.sv
// N-channel L2 request block: round-robin inside each channel, weighted
// round-robin across channels, winner queued in an elastic FIFO toward the
// L2 slave. Responses return to masters through the one-hot ID generated here.
module l2_req_block_nch
  import l2_xbar_pkg::*;
#(
  parameter int ADDR_WIDTH   = L2_ADDR_W,
  parameter int DATA_WIDTH   = L2_DATA_W,
  parameter int BE_WIDTH     = DATA_WIDTH / 8,
  parameter int N_CH         = 2,
  parameter int MPC          = 4,
  parameter int ID_WIDTH     = N_CH * MPC,
  parameter int WEIGHT_WIDTH = 4,
  parameter int OUT_DEPTH    = 2
) (
  input logic              clk,
  input logic              rst,
  l2_req_block_nch_if.slave bus
);

  localparam int N_M   = N_CH * MPC;
  localparam int RR_W  = (MPC > 1) ? $clog2(MPC) : 1;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int LVL_W = $clog2(OUT_DEPTH) + 1;

  // Arbitration state
  logic [RR_W-1:0]         r_rr [N_CH];
  logic [CH_W-1:0]         r_cur_ch;
  logic [WEIGHT_WIDTH-1:0] r_credit;

  // Arbitration decode
  logic [L2_SRCH_W-1:0]    w_mreq;
  logic [L2_SRCH_W-1:0]    w_creq;
  logic [N_CH-1:0]         w_ch_req;
  int                      w_cand [N_CH];
  int                      w_sel;
  int                      w_win;
  logic                    w_keep;
  logic                    w_accept;
  logic [N_M-1:0]          w_gnt;
  logic [WEIGHT_WIDTH-1:0] w_weight_sel;
  logic [WEIGHT_WIDTH-1:0] w_weff;

  // FIFO connections
  l2_entry_t               w_push_entry;
  l2_entry_t               w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic [LVL_W-1:0]        w_level;

  // Per-channel candidate, channel selection, grant and the entry to enqueue.
  always_comb begin
    w_mreq       = '0;
    w_creq       = '0;
    w_ch_req     = '0;
    w_sel        = 0;
    w_win        = 0;
    w_gnt        = '0;
    w_push_entry = '0;

    for (int ch = 0; ch < N_CH; ch++) begin
      w_mreq           = '0;
      w_mreq[MPC-1:0]  = bus.data_req_i[ch*MPC +: MPC];
      w_ch_req[ch]     = |bus.data_req_i[ch*MPC +: MPC];
      w_cand[ch]       = rr_search(w_mreq, int'(r_rr[ch]), MPC);
    end

    // Stay on the current channel while it still has credit; otherwise look
    // at the other channels first so the current one is considered last.
    w_creq[N_CH-1:0] = w_ch_req;
    w_keep = w_ch_req[r_cur_ch] && (r_credit != '0);
    if (w_keep) begin
      w_sel = int'(r_cur_ch);
    end else begin
      w_sel = rr_search(w_creq, (int'(r_cur_ch) + 1) % N_CH, N_CH);
    end
    w_win = w_sel * MPC + w_cand[w_sel];

    w_weight_sel = bus.ch_weight_i[w_sel*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    w_weff = (w_weight_sel == '0) ? WEIGHT_WIDTH'(L2_W_ZERO_AS) : w_weight_sel;

    // No grant while in reset: the FIFO would drop the push anyway.
    w_accept = (|bus.data_req_i) & ~w_full & ~rst;
    if (w_accept) begin
      w_gnt[w_win] = 1'b1;
    end else begin
      w_gnt = '0;
    end

    w_push_entry.add        = bus.data_add_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
    w_push_entry.wen        = bus.data_wen_i[w_win];
    w_push_entry.wdata      = bus.data_wdata_i[w_win*DATA_WIDTH +: DATA_WIDTH];
    w_push_entry.be         = bus.data_be_i[w_win*BE_WIDTH +: BE_WIDTH];
    w_push_entry.id         = '0;
    w_push_entry.id[w_win]  = 1'b1;
  end

  // Advance the round-robin pointers and channel credit only on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        r_rr[ch] <= '0;
      end
      r_cur_ch <= CH_W'(N_CH - 1);
      r_credit <= '0;
    end else if (w_accept) begin
      r_rr[w_sel] <= RR_W'((w_cand[w_sel] + 1) % MPC);
      if (w_keep) begin
        r_credit <= r_credit - WEIGHT_WIDTH'(1);
      end else begin
        r_cur_ch <= CH_W'(w_sel);
        r_credit <= w_weff - WEIGHT_WIDTH'(1);
      end
    end else begin
      r_cur_ch <= r_cur_ch;
      r_credit <= r_credit;
    end
  end

  assign w_pop = ~w_empty & bus.data_gnt_i;

  l2_req_fifo #(
    .DEPTH (OUT_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign bus.data_gnt_o     = w_gnt;
  assign bus.data_req_o     = ~w_empty;
  assign bus.data_add_o     = w_head.add;
  assign bus.data_wen_o     = w_head.wen;
  assign bus.data_wdata_o   = w_head.wdata;
  assign bus.data_be_o      = w_head.be;
  assign bus.data_ID_o      = w_head.id;
  assign bus.fifo_level_o   = w_level;
  assign bus.data_r_valid_o = {N_M{bus.data_r_valid_i}} & bus.data_r_ID_i;

endmodule

// File: tb/tb_l2_req_block_nch.sv
// Directed bench for l2_req_block_nch at default parameters (2 channels x 4 masters).
module tb_l2_req_block_nch;
  import l2_xbar_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  l2_req_block_nch_if bus ();

  l2_req_block_nch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold reset across one edge, check the cleared state, release after the next edge.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_req_o", 64'(bus.data_req_o), 64'd0);
    check_val("rst_gnt_o", 64'(bus.data_gnt_o), 64'h00);
    check_val("rst_level", 64'(bus.fifo_level_o), 64'd0);
    check_val("rst_id_o",  64'(bus.data_ID_o), 64'h00);
    check_val("rst_add_o", 64'(bus.data_add_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int exp_wrr [8];
  int exp_zero [6];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    bus.data_req_i     = 8'hFF;
    bus.data_add_i     = '0;
    bus.data_wen_i     = 8'hFF;
    bus.data_wdata_i   = '0;
    bus.data_be_i      = '1;
    bus.ch_weight_i    = {4'd1, 4'd1};
    bus.data_gnt_i     = 1'b1;
    bus.data_r_valid_i = 1'b0;
    bus.data_r_ID_i    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus.data_add_i[i*32 +: 32] = 32'h1000_0000 + 32'(i * 16);
    end
    exp_wrr  = '{0, 1, 2, 4, 3, 0, 1, 5};
    exp_zero = '{0, 4, 1, 5, 2, 6};

    // Reset with all masters requesting
    #2;
    do_reset();

    // Single request from master 5
    bus.data_req_i = 8'h20;
    bus.data_add_i[5*32 +: 32] = 32'h1C00_0040;
    @(negedge clk);
    check_val("single_gnt", 64'(bus.data_gnt_o), 64'h20);
    next_cycle();
    bus.data_req_i = 8'h00;
    @(negedge clk);
    check_val("single_req_o", 64'(bus.data_req_o), 64'd1);
    check_val("single_add_o", 64'(bus.data_add_o), 64'h1C00_0040);
    check_val("single_id_o",  64'(bus.data_ID_o), 64'h20);
    check_val("single_gnt_idle", 64'(bus.data_gnt_o), 64'h00);
    next_cycle();
    @(negedge clk);
    check_val("single_drained", 64'(bus.data_req_o), 64'd0);

    // Weighted order: ch0 weight 3, ch1 weight 1
    bus.ch_weight_i = {4'd1, 4'd3};
    bus.data_req_i  = 8'hFF;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_val($sformatf("wrr_gnt%0d", k), 64'(bus.data_gnt_o), 64'(8'd1 << exp_wrr[k]));
      if (k > 0) begin
        check_val($sformatf("wrr_id%0d", k), 64'(bus.data_ID_o), 64'(8'd1 << exp_wrr[k-1]));
      end
      next_cycle();
    end

    // Zero weights behave as one: strict channel alternation (reset also flushes the queued entry)
    bus.ch_weight_i = {4'd0, 4'd0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val($sformatf("zw_gnt%0d", k), 64'(bus.data_gnt_o), 64'(8'd1 << exp_zero[k]));
      next_cycle();
    end

    // Backpressure: slave stalls, master 0 keeps requesting with a new address each grant
    bus.data_req_i = 8'h00;
    do_reset();
    bus.data_gnt_i = 1'b0;
    bus.data_req_i = 8'h01;
    bus.data_add_i[31:0] = 32'hA000_0000;
    @(negedge clk);
    check_val("bp_gnt1", 64'(bus.data_gnt_o), 64'h01);
    next_cycle();
    bus.data_add_i[31:0] = 32'hA000_0004;
    @(negedge clk);
    check_val("bp_gnt2", 64'(bus.data_gnt_o), 64'h01);
    check_val("bp_level1", 64'(bus.fifo_level_o), 64'd1);
    next_cycle();
    bus.data_add_i[31:0] = 32'hA000_0008;
    @(negedge clk);
    check_val("bp_full_gnt", 64'(bus.data_gnt_o), 64'h00);
    check_val("bp_full_level", 64'(bus.fifo_level_o), 64'd2);
    check_val("bp_head0", 64'(bus.data_add_o), 64'hA000_0000);
    bus.data_gnt_i = 1'b1;
    check_val("bp_full_gnt_pop", 64'(bus.data_gnt_o), 64'h00);
    next_cycle();
    @(negedge clk);
    check_val("bp_level_after_pop", 64'(bus.fifo_level_o), 64'd1);
    check_val("bp_head1", 64'(bus.data_add_o), 64'hA000_0004);
    check_val("bp_gnt3", 64'(bus.data_gnt_o), 64'h01);
    next_cycle();
    bus.data_req_i = 8'h00;
    @(negedge clk);
    check_val("bp_level_steady", 64'(bus.fifo_level_o), 64'd1);
    check_val("bp_head2", 64'(bus.data_add_o), 64'hA000_0008);
    check_val("bp_id2", 64'(bus.data_ID_o), 64'h01);
    next_cycle();
    @(negedge clk);
    check_val("bp_empty_level", 64'(bus.fifo_level_o), 64'd0);
    check_val("bp_empty_req", 64'(bus.data_req_o), 64'd0);

    // Response routing
    bus.data_r_valid_i = 1'b1;
    bus.data_r_ID_i    = 8'h80;
    #1;
    check_val("rsp_m7", 64'(bus.data_r_valid_o), 64'h80);
    bus.data_r_ID_i    = 8'h04;
    #1;
    check_val("rsp_m2", 64'(bus.data_r_valid_o), 64'h04);
    bus.data_r_ID_i    = 8'h00;
    #1;
    check_val("rsp_noid", 64'(bus.data_r_valid_o), 64'h00);
    bus.data_r_valid_i = 1'b0;
    bus.data_r_ID_i    = 8'h80;
    #1;
    check_val("rsp_novalid", 64'(bus.data_r_valid_o), 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
